// File: rtl/wash_sequencer.sv
// -----------------------------------------------------------------------------
// wash_sequencer
//
// Run-phase controller for the washer. On entry to runST the packed 26-bit
// program word is latched and its eight timed segments are stepped through,
// one second per tick. The sequencer drives the fill valve, the drain valve
// and the drum motor, and reports the current segment, the seconds left in it
// and the seconds left in the whole program. done pulses once on completion.
//
// FSM states:
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for runST; program word sampled on the entry cycle
//   RUN    | stepping segments (runST), frozen (pause/error), or aborting
//   FINISH | program complete; done on the first cycle only, parked until
//          | the top-level state leaves runST/finishST
//
// Ports:
//   cp        in   system clock, all state changes on posedge
//   rst_n     in   asynchronous active-low reset
//   tick      in   one-cycle 1 Hz enable, synchronous to cp
//   state     in   top-level state (0 shutDown .. 6 finish)
//   data      in   program word, segment 0 in the MSBs, units are seconds
//   seg       out  current segment index
//   segRemain out  seconds left in the current segment
//   remain    out  seconds left in the whole program
//   inValve   out  water-in valve (segments 0, 4)
//   outValve  out  drain valve (segments 2, 3, 6, 7)
//   motor     out  drum motor (segments 1, 3, 5, 7)
//   busy      out  high while in RUN
//   done      out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module wash_sequencer #(
  parameter int SEGS  = 8,
  parameter int REM_W = 8
) (
  input  logic             cp,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [2:0]       state,
  input  logic [25:0]      data,
  output logic [2:0]       seg,
  output logic [3:0]       segRemain,
  output logic [REM_W-1:0] remain,
  output logic             inValve,
  output logic             outValve,
  output logic             motor,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(SEGS);

  localparam logic [2:0] ST_SHUTDOWN = 3'd0;
  localparam logic [2:0] ST_BEGIN    = 3'd1;
  localparam logic [2:0] ST_SET      = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_FINISH   = 3'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } fsm_e;

  // One 4-bit duration per segment; 3-bit fields are zero-extended.
  typedef logic [SEGS-1:0][3:0] prog_t;

  fsm_e             fsm_q, fsm_d;
  prog_t            prog_q, prog_d;
  logic [2:0]       seg_d;
  logic [3:0]       seg_remain_d;
  logic [REM_W-1:0] remain_d;
  logic [2:0]       act_d;
  logic             busy_d;
  logic             done_d;

  prog_t            load_prog;
  logic [REM_W-1:0] load_sum;
  logic [3:0]       load_nz;
  logic [3:0]       next_nz;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic prog_t unpack_prog(input logic [25:0] w);
    prog_t p;
    p    = '0;
    p[0] = {1'b0, w[25:23]};
    p[1] = w[22:19];
    p[2] = {1'b0, w[18:16]};
    p[3] = {1'b0, w[15:13]};
    p[4] = {1'b0, w[12:10]};
    p[5] = w[9:6];
    p[6] = {1'b0, w[5:3]};
    p[7] = {1'b0, w[2:0]};
    return p;
  endfunction

  function automatic logic [REM_W-1:0] prog_sum(input prog_t p);
    logic [REM_W-1:0] s;
    s = '0;
    for (int i = 0; i < SEGS; i++) begin
      s = s + REM_W'(p[IDX_W'(i)]);
    end
    return s;
  endfunction

  // Lowest segment index >= lo with a nonzero duration. Result is
  // {found, index}. Scanning downward lets the lowest hit win, which is
  // what makes zero-length segments disappear without a dead cycle.
  function automatic logic [3:0] find_nz(input prog_t p, input logic [3:0] lo);
    logic [3:0] r;
    r = '0;
    for (int i = SEGS - 1; i >= 0; i--) begin
      if ((4'(i) >= lo) && (p[IDX_W'(i)] != 4'd0)) begin
        r = {1'b1, 3'(i)};
      end
    end
    return r;
  endfunction

  // {inValve, outValve, motor} for a segment.
  function automatic logic [2:0] act_for(input logic [2:0] s);
    logic [2:0] a;
    case (s)
      3'd0:    a = 3'b100;
      3'd1:    a = 3'b001;
      3'd2:    a = 3'b010;
      3'd3:    a = 3'b011;
      3'd4:    a = 3'b100;
      3'd5:    a = 3'b001;
      3'd6:    a = 3'b010;
      3'd7:    a = 3'b011;
      default: a = 3'b000;
    endcase
    return a;
  endfunction

  // ---------------------------------------------------------------------------
  // Lookahead on the live word (used only in the load cycle) and on the
  // latched program (used when the current segment hits its terminal count).
  // ---------------------------------------------------------------------------
  always_comb begin
    load_prog = unpack_prog(data);
    load_sum  = prog_sum(load_prog);
    load_nz   = find_nz(load_prog, 4'd0);
    next_nz   = find_nz(prog_q, {1'b0, seg} + 4'd1);
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    fsm_d        = fsm_q;
    prog_d       = prog_q;
    seg_d        = seg;
    seg_remain_d = segRemain;
    remain_d     = remain;
    act_d        = 3'b000;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    case (fsm_q)
      IDLE: begin
        seg_d        = '0;
        seg_remain_d = '0;
        remain_d     = '0;
        if (state == ST_RUN) begin
          // A tick arriving in this cycle is deliberately not consumed.
          prog_d = load_prog;
          if (load_nz[3]) begin
            fsm_d        = RUN;
            seg_d        = load_nz[2:0];
            seg_remain_d = load_prog[load_nz[2:0]];
            remain_d     = load_sum;
            act_d        = act_for(load_nz[2:0]);
            busy_d       = 1'b1;
          end else begin
            fsm_d  = FINISH;
            done_d = 1'b1;
          end
        end
      end

      RUN: begin
        case (state)
          ST_RUN: begin
            busy_d = 1'b1;
            act_d  = act_for(seg);
            if (tick) begin
              remain_d = remain - REM_W'(1);
              if (segRemain == 4'd1) begin
                if (next_nz[3]) begin
                  seg_d        = next_nz[2:0];
                  seg_remain_d = prog_q[next_nz[2:0]];
                  act_d        = act_for(next_nz[2:0]);
                end else begin
                  fsm_d        = FINISH;
                  seg_d        = '0;
                  seg_remain_d = '0;
                  remain_d     = '0;
                  act_d        = 3'b000;
                  busy_d       = 1'b0;
                  done_d       = 1'b1;
                end
              end else begin
                seg_remain_d = segRemain - 4'd1;
              end
            end
          end

          ST_SHUTDOWN, ST_BEGIN, ST_SET: begin
            fsm_d        = IDLE;
            seg_d        = '0;
            seg_remain_d = '0;
            remain_d     = '0;
          end

          // Pause, error and anything else: hold counts, actuators off,
          // ticks dropped on the floor.
          default: begin
            busy_d = 1'b1;
          end
        endcase
      end

      FINISH: begin
        seg_d        = '0;
        seg_remain_d = '0;
        remain_d     = '0;
        if ((state != ST_RUN) && (state != ST_FINISH)) begin
          fsm_d = IDLE;
        end
      end

      default: begin
        fsm_d        = IDLE;
        seg_d        = '0;
        seg_remain_d = '0;
        remain_d     = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers; every output is a flop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      prog_q    <= '0;
      seg       <= '0;
      segRemain <= '0;
      remain    <= '0;
      inValve   <= 1'b0;
      outValve  <= 1'b0;
      motor     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      prog_q    <= prog_d;
      seg       <= seg_d;
      segRemain <= seg_remain_d;
      remain    <= remain_d;
      inValve   <= act_d[2];
      outValve  <= act_d[1];
      motor     <= act_d[0];
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_wash_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wash_sequencer
//
// Directed scenarios with fixed expectations, then randomized programs and
// state sequences. A reference model tracks elapsed program seconds; the
// expected segment and counters are derived from cumulative segment
// boundaries and compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_wash_sequencer;

  localparam logic [2:0] ST_SHUT  = 3'd0;
  localparam logic [2:0] ST_BEGIN = 3'd1;
  localparam logic [2:0] ST_SET   = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;
  localparam logic [2:0] ST_PAUSE = 3'd5;
  localparam logic [2:0] ST_FIN   = 3'd6;

  localparam logic [25:0] WRD   = 26'b011_1010_100_101_011_1000_100_101;
  localparam logic [25:0] DONLY = 26'b000_0000_000_000_000_0000_100_101;

  logic        cp    = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick  = 1'b0;
  logic [2:0]  state = ST_SHUT;
  logic [25:0] data  = '0;

  logic [2:0]  seg;
  logic [3:0]  segRemain;
  logic [7:0]  remain;
  logic        inValve, outValve, motor, busy, done;

  int errs       = 0;
  int checks     = 0;
  int done_total = 0;
  bit chk_en     = 1'b0;

  // Reference model: mode 0 idle, 1 running, 2 finished.
  int m_mode  = 0;
  int m_prog [8];
  int m_total = 0;
  int m_el    = 0;
  bit m_done  = 1'b0;
  bit m_act   = 1'b0;

  wash_sequencer dut (
    .cp        (cp),
    .rst_n     (rst_n),
    .tick      (tick),
    .state     (state),
    .data      (data),
    .seg       (seg),
    .segRemain (segRemain),
    .remain    (remain),
    .inValve   (inValve),
    .outValve  (outValve),
    .motor     (motor),
    .busy      (busy),
    .done      (done)
  );

  always #5 cp = ~cp;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model update, evaluated on the same edge the DUT sees.
  always @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  = 0;
      m_total = 0;
      m_el    = 0;
      m_done  = 1'b0;
      m_act   = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_mode)
        0: begin
          if (state == ST_RUN) begin
            m_prog[0] = int'(data[25:23]);
            m_prog[1] = int'(data[22:19]);
            m_prog[2] = int'(data[18:16]);
            m_prog[3] = int'(data[15:13]);
            m_prog[4] = int'(data[12:10]);
            m_prog[5] = int'(data[9:6]);
            m_prog[6] = int'(data[5:3]);
            m_prog[7] = int'(data[2:0]);
            m_total = 0;
            foreach (m_prog[i]) m_total += m_prog[i];
            m_el = 0;
            if (m_total == 0) begin
              m_mode = 2;
              m_done = 1'b1;
            end else begin
              m_mode = 1;
              m_act  = 1'b1;
            end
          end
        end
        1: begin
          if (state == ST_RUN) begin
            m_act = 1'b1;
            if (tick) begin
              m_el++;
              if (m_el == m_total) begin
                m_mode = 2;
                m_done = 1'b1;
              end
            end
          end else if (state == ST_SHUT || state == ST_BEGIN || state == ST_SET) begin
            m_mode = 0;
          end else begin
            m_act = 1'b0;
          end
        end
        default: begin
          if (state != ST_RUN && state != ST_FIN) m_mode = 0;
        end
      endcase
    end
  end

  // Continuous comparison against the model.
  always @(negedge cp) begin : cmp
    int e_seg, e_sr, e_rem, e_in, e_out, e_mot, e_busy, acc;
    if (done) done_total++;
    if (chk_en) begin
      e_seg = 0; e_sr = 0; e_rem = 0; e_in = 0; e_out = 0; e_mot = 0; e_busy = 0;
      if (m_mode == 1) begin
        e_busy = 1;
        e_rem  = m_total - m_el;
        acc    = 0;
        for (int i = 0; i < 8; i++) begin
          if (e_sr == 0 && m_el < acc + m_prog[i]) begin
            e_seg = i;
            e_sr  = acc + m_prog[i] - m_el;
          end
          acc += m_prog[i];
        end
        if (m_act) begin
          e_in  = (e_seg == 0 || e_seg == 4) ? 1 : 0;
          e_out = (e_seg == 2 || e_seg == 3 || e_seg == 6 || e_seg == 7) ? 1 : 0;
          e_mot = (e_seg == 1 || e_seg == 3 || e_seg == 5 || e_seg == 7) ? 1 : 0;
        end
      end
      chk("m_seg",       int'(seg),       e_seg);
      chk("m_segRemain", int'(segRemain), e_sr);
      chk("m_remain",    int'(remain),    e_rem);
      chk("m_inValve",   int'(inValve),   e_in);
      chk("m_outValve",  int'(outValve),  e_out);
      chk("m_motor",     int'(motor),     e_mot);
      chk("m_busy",      int'(busy),      e_busy);
      chk("m_done",      int'(done),      int'(m_done));
    end
  end

  // Apply inputs for one edge; returns 2 time units after that edge.
  task automatic cyc(input logic [2:0] st, input logic tk);
    state = st;
    tick  = tk;
    @(posedge cp);
    #2;
    tick = 1'b0;
  endtask

  task automatic ticks(input int n, input logic [2:0] st);
    repeat (n) begin
      cyc(st, 1'b0);
      cyc(st, 1'b0);
      cyc(st, 1'b0);
      cyc(st, 1'b1);
    end
  endtask

  function automatic logic [25:0] rand_word();
    int f [8];
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 2) == 0) f[i] = 0;
      else f[i] = $urandom_range(1, (i == 1 || i == 5) ? 15 : 7);
    end
    return {3'(f[0]), 4'(f[1]), 3'(f[2]), 3'(f[3]),
            3'(f[4]), 4'(f[5]), 3'(f[6]), 3'(f[7])};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [2:0] st;
    int r;

    rst_n = 1'b0;
    repeat (2) @(posedge cp);
    #2;
    chk_en = 1'b1;
    chk("rst_seg",    int'(seg),    0);
    chk("rst_remain", int'(remain), 0);
    chk("rst_busy",   int'(busy),   0);
    chk("rst_done",   int'(done),   0);
    rst_n = 1'b1;
    cyc(ST_SHUT, 1'b0);

    // Full WRD program; a tick coinciding with the load is ignored.
    data = WRD;
    cyc(ST_RUN, 1'b1);
    chk("wrd_load_seg",    int'(seg),       0);
    chk("wrd_load_sr",     int'(segRemain), 3);
    chk("wrd_load_remain", int'(remain),    42);
    chk("wrd_load_in",     int'(inValve),   1);
    chk("wrd_load_busy",   int'(busy),      1);
    data = ~WRD;
    ticks(3, ST_RUN);
    chk("wrd_t3_seg",   int'(seg),       1);
    chk("wrd_t3_sr",    int'(segRemain), 10);
    chk("wrd_t3_motor", int'(motor),     1);
    chk("wrd_t3_in",    int'(inValve),   0);
    chk("wrd_t3_rem",   int'(remain),    39);
    ticks(9, ST_RUN);
    chk("wrd_rem30", int'(remain), 30);

    // Pause with ticks; nothing moves.
    cyc(ST_PAUSE, 1'b0);
    chk("pause_motor", int'(motor),  0);
    chk("pause_busy",  int'(busy),   1);
    chk("pause_rem",   int'(remain), 30);
    ticks(10, ST_PAUSE);
    chk("pause_rem_after", int'(remain), 30);
    cyc(ST_RUN, 1'b0);
    chk("resume_seg",   int'(seg),    1);
    chk("resume_motor", int'(motor),  1);
    chk("resume_rem",   int'(remain), 30);

    d0 = done_total;
    ticks(30, ST_RUN);
    chk("wrd_done",      int'(done),   1);
    chk("wrd_fin_rem",   int'(remain), 0);
    chk("wrd_fin_busy",  int'(busy),   0);
    cyc(ST_RUN, 1'b1);
    chk("wrd_done_once", int'(done),   0);
    chk("wrd_no_reload", int'(busy),   0);
    cyc(ST_FIN, 1'b0);
    chk("wrd_done_count", done_total - d0, 1);
    cyc(ST_SET, 1'b0);

    // Abort at segment 5.
    data = WRD;
    cyc(ST_RUN, 1'b0);
    ticks(26, ST_RUN);
    chk("abort_at_seg", int'(seg), 5);
    d0 = done_total;
    cyc(ST_SET, 1'b0);
    chk("abort_seg",    int'(seg),       0);
    chk("abort_sr",     int'(segRemain), 0);
    chk("abort_remain", int'(remain),    0);
    chk("abort_busy",   int'(busy),      0);
    chk("abort_motor",  int'(motor),     0);
    cyc(ST_SET, 1'b0);
    chk("abort_no_done", done_total - d0, 0);
    cyc(ST_RUN, 1'b0);
    chk("reload_remain", int'(remain), 42);
    chk("reload_seg",    int'(seg),    0);

    // Asynchronous reset in segment 2.
    ticks(14, ST_RUN);
    chk("pre_rst_seg", int'(seg), 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_seg",      int'(seg),      0);
    chk("arst_remain",   int'(remain),   0);
    chk("arst_outValve", int'(outValve), 0);
    chk("arst_busy",     int'(busy),     0);
    repeat (2) @(posedge cp);
    #2;
    rst_n = 1'b1;
    cyc(ST_RUN, 1'b0);
    chk("post_rst_seg",    int'(seg),       0);
    chk("post_rst_remain", int'(remain),    42);
    chk("post_rst_sr",     int'(segRemain), 3);

    // Drain/spin-only program: leading zero segments skipped.
    cyc(ST_SHUT, 1'b0);
    data = DONLY;
    cyc(ST_RUN, 1'b0);
    chk("donly_seg",    int'(seg),       6);
    chk("donly_sr",     int'(segRemain), 4);
    chk("donly_remain", int'(remain),    9);
    chk("donly_out",    int'(outValve),  1);
    chk("donly_motor0", int'(motor),     0);
    ticks(4, ST_RUN);
    chk("donly_seg7",  int'(seg),      7);
    chk("donly_motor", int'(motor),    1);
    chk("donly_out7",  int'(outValve), 1);
    chk("donly_rem5",  int'(remain),   5);
    ticks(5, ST_RUN);
    chk("donly_done", int'(done), 1);

    // Empty program.
    cyc(ST_SHUT, 1'b0);
    data = '0;
    cyc(ST_RUN, 1'b0);
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    cyc(ST_RUN, 1'b0);
    chk("zero_done_once", int'(done), 0);
    chk("zero_busy2",     int'(busy), 0);

    // Randomized programs and state sequences against the model.
    for (int p = 0; p < 16; p++) begin
      cyc(ST_SHUT, 1'b0);
      data = rand_word();
      for (int c = 0; c < 300; c++) begin
        r = $urandom_range(0, 99);
        if (r < 78)                 st = ST_RUN;
        else if (r < 88)            st = ST_PAUSE;
        else if (r < 97)            st = ST_ERR;
        else if (p % 2 == 0)        st = ST_RUN;
        else if (r == 97)           st = ST_SET;
        else if (r == 98)           st = ST_SHUT;
        else                        st = ST_BEGIN;
        if ($urandom_range(0, 9) == 0) data = rand_word();
        cyc(st, 1'($urandom_range(0, 1)));
      end
    end

    cyc(ST_SHUT, 1'b0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
